div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst as in the rest of the pipeline.
REQ-002 Port `clk`: input, 1 bit; rising-edge clock.
REQ-003 Port `rst`: input, 1 bit; asynchronous active-low reset.
REQ-004 Port `signed_div_i`: input, 1 bit; 1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i`.
REQ-005 Port `opdata1_i`: input, Reg_t (32 bits); dividend, sampled with `start_i`.
REQ-006 Port `opdata2_i`: input, Reg_t (32 bits); divisor, sampled with `start_i`.
REQ-007 Port `start_i`: input, 1 bit; request from the EX stage; held high until `ready_o` is seen.
REQ-008 Port `annul_i`: input, 1 bit; abort the operation in flight (flush).
REQ-009 Port `result_o`: output, DoubleReg_t (64 bits); {remainder, quotient}, routed to EX hi/lo and then into ex_mem.
REQ-010 Port `ready_o`: output, 1 bit; `result_o` is valid.

Function
REQ-011 The block SHALL implement states DIV_FREE, DIV_BYZERO, DIV_ON and DIV_END.
REQ-012 In DIV_FREE, an edge with start_i=1, annul_i=0 and opdata2_i=0 SHALL go to DIV_BYZERO.
REQ-013 In DIV_FREE, an edge with start_i=1, annul_i=0 and opdata2_i≠0 SHALL latch |operands| (signed mode) or raw operands, clear the iteration count, and go to DIV_ON.
REQ-014 DIV_BYZERO SHALL go to DIV_END on the next edge with result = 64'h0.
REQ-015 DIV_ON SHALL perform one restoring shift-subtract step per edge over 32 steps, then go to DIV_END with the sign-corrected result.
REQ-016 Ready timing SHALL be: ready_o high 33 edges after the start edge for a normal divide, and 2 edges after it for divide-by-zero.
REQ-017 Sign correction SHALL apply in signed mode only: quotient negated when the operand signs differ; remainder takes the dividend's sign.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-019 ready_o SHALL equal 1 exactly while in DIV_END.
REQ-020 result_o SHALL be 0 outside DIV_END.
REQ-021 DIV_END SHALL hold while start_i=1 and go to DIV_FREE on the first edge with start_i=0 (result cleared).
REQ-022 annul_i=1 in DIV_ON or DIV_BYZERO SHALL go to DIV_FREE on that edge with no ready pulse.
REQ-023 annul_i in DIV_END SHALL be ignored; the exit follows start_i.
REQ-024 start_i and annul_i high together in DIV_FREE SHALL leave the block in DIV_FREE.
REQ-025 Operand changes after the start edge SHALL have no effect.

Reset
REQ-026 rst=0 SHALL asynchronously force: state DIV_FREE, iteration count 0, ready_o=0, result_o=64'h0, operand/partial-remainder registers 0.
REQ-027 Reset asserted mid-DIV_ON SHALL discard the operation; after release the block SHALL accept a new start on the first edge.

Configuration
REQ-028 Macro DIV_EARLY_EXIT_EN SHALL be the single compile-time option.
REQ-029 With DIV_EARLY_EXIT_EN defined, a start in DIV_FREE with |dividend| < |divisor| (divisor≠0) SHALL go directly to DIV_END with quotient 0 and remainder = original dividend, so ready_o is high 1 edge after the start edge.
REQ-030 Without DIV_EARLY_EXIT_EN, such operands SHALL take the full 33-edge path with an identical numeric result.

Structure
REQ-031 The shared package SHALL hold the DivState_t enum (four states) and constants DivResultReady/DivResultNotReady, DivStart/DivStop and DIV_ITER = 32.
REQ-032 Reg_t and DoubleReg_t SHALL be reused from the existing shared definitions.
REQ-033 The block SHALL have no sub-module: a single sequential process plus a combinational subtract/abs path.

Verification
REQ-034 Unsigned 100/7: ready at edge 33 after start, result_o = {32'd2, 32'd14}.
REQ-035 Signed -7/2 (0xFFFFFFF9, 0x2): result_o = {0xFFFFFFFF, 0xFFFFFFFD}; signed 0x80000000/0xFFFFFFFF: {0x0, 0x80000000}.
REQ-036 Divide by zero, 5/0: ready at edge 2, result_o = 64'h0; with start_i held 5 more cycles, ready_o stays 1 and drops 1 edge after start_i falls.
REQ-037 Unsigned 1000/3 with annul_i pulsed at step 10: DIV_FREE next edge, ready_o never rises; an immediate 9/3 then returns {0, 3} at edge 33.
REQ-038 Unsigned 5/9: ready at edge 1 with DIV_EARLY_EXIT_EN, at edge 33 without; result {5, 0} in both builds.
REQ-039 rst pulsed low at step 20 of 100/7: outputs 0 immediately; a new 100/7 after release completes correctly.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle divider (div_unit).
package div_unit_pkg;

  typedef logic [31:0] Reg_t;
  typedef logic [63:0] DoubleReg_t;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } DivState_t;

  localparam logic       DivResultReady    = 1'b1;
  localparam logic       DivResultNotReady = 1'b0;
  localparam logic       DivStart          = 1'b1;
  localparam logic       DivStop           = 1'b0;
  localparam logic [5:0] DIV_ITER          = 6'd32;

endpackage

// File: rtl/div_unit.sv
// Restoring radix-2 divider, 32 steps, {remainder, quotient} result.
// Optional macro DIV_EARLY_EXIT_EN: finish at the start edge when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       signed_div_i,
  input  Reg_t       opdata1_i,
  input  Reg_t       opdata2_i,
  input  logic       start_i,
  input  logic       annul_i,
  output DoubleReg_t result_o,
  output logic       ready_o,
  output DivState_t  state
);

  // Handshake: start_i is held high until ready_o is seen; ready_o stays high
  // (with result_o valid) until the first edge on which start_i is low.

  logic [5:0] cnt;
  Reg_t       quot;
  Reg_t       divisor;
  Reg_t       rem;
  logic       neg_q;
  logic       neg_r;

  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        q_bit;
  Reg_t        rem_next;
  Reg_t        quot_next;
  Reg_t        q_fix;
  Reg_t        r_fix;
  Reg_t        abs_a;
  Reg_t        abs_b;

  always_comb begin
    rem_shift = {rem, quot[31]};
    diff      = rem_shift - {1'b0, divisor};
    q_bit     = ~diff[32];
    rem_next  = q_bit ? diff[31:0] : rem_shift[31:0];
    quot_next = {quot[30:0], q_bit};
    q_fix     = neg_q ? -quot_next : quot_next;
    r_fix     = neg_r ? -rem_next : rem_next;
    // 0x80000000 keeps its own bit pattern, which is its correct unsigned magnitude.
    abs_a     = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    abs_b     = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      quot     <= '0;
      divisor  <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end
`ifdef DIV_EARLY_EXIT_EN
            else if (abs_a < abs_b) begin
              state    <= DIV_END;
              ready_o  <= DivResultReady;
              result_o <= {opdata1_i, 32'h0};
            end
`endif
            else begin
              state   <= DIV_ON;
              cnt     <= '0;
              quot    <= abs_a;
              divisor <= abs_b;
              rem     <= '0;
              neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              neg_r   <= signed_div_i & opdata1_i[31];
            end
          end
        end
        DIV_BYZERO: begin
          if (annul_i) begin
            state <= DIV_FREE;
          end else begin
            state    <= DIV_END;
            ready_o  <= DivResultReady;
            result_o <= '0;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_FREE;
            cnt   <= '0;
          end else if (cnt == DIV_ITER - 6'd1) begin
            // Final step folds straight into the sign-corrected result.
            state    <= DIV_END;
            cnt      <= '0;
            ready_o  <= DivResultReady;
            result_o <= {r_fix, q_fix};
          end else begin
            quot <= quot_next;
            rem  <= rem_next;
            cnt  <= cnt + 6'd1;
          end
        end
        DIV_END: begin
          if (start_i == DivStop) begin
            state    <= DIV_FREE;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule
